mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit, directly downstream of the EX-stage ALU.
//  - Takes ALUResult as the effective address, plus rs2 store data and funct3 from the EX/MEM register.
//  - Drives a word-wide data memory over a req/gnt/rvalid handshake that can insert wait states.
//  - Forms byte enables and store-lane replication; sign/zero-extends load data.
//  - Holds stall high so the pipeline freezes until the access completes.
// PARAMETERS
//  DATA_WIDTH  32  data/address width; only 32 is supported
//  BE_WIDTH    4   byte enables, DATA_WIDTH/8
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-high
//  valid_i      in   1   EX/MEM register holds a valid instruction
//  MemRead      in   1   load request
//  MemWrite     in   1   store request
//  Funct3       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  Addr         in   32  effective address (ALUResult)
//  WrData       in   32  store data, in the low lanes
//  stall        out  1   freeze PC/IF/ID/EX/EX-MEM while high
//  done         out  1   one-cycle pulse: access complete
//  ReadData     out  32  extended load data; valid while done=1, held until the next load
//  err          out  1   one-cycle pulse: misaligned/illegal access; no memory request issued
//  mem_req      out  1   request to memory
//  mem_we       out  1   1 = write
//  mem_addr     out  32  {Addr[31:2],2'b00}
//  mem_be       out  4   byte enables
//  mem_wdata    out  32  lane-replicated store data
//  mem_gnt      in   1   request accepted this cycle
//  mem_rvalid   in   1   mem_rdata valid; at least 1 cycle after gnt
//  mem_rdata    in   32  read word
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT_R, DONE.
//  - Reset values: state=IDLE; all outputs 0, including ReadData and the mem_* buses.
//  - Start = valid_i & (MemRead|MemWrite) in IDLE.
//  - Access checks at start:
//    - MemRead&MemWrite both set, or Funct3 not in {000,001,010,100,101}, or store with Funct3 100/101: illegal.
//    - H/HU with Addr[0]=1, or W with Addr[1:0]!=0: misaligned.
//    - Illegal or misaligned: err=1 for that cycle, stall=0, state stays IDLE, no mem_req.
//  - Legal start:
//    - Latch addr, funct3, we and wdata.
//    - stall=1 combinationally in the same cycle; next state REQ.
//  - REQ state:
//    - mem_req=1; mem_addr/mem_we/mem_be/mem_wdata come from latched values and stay stable until gnt.
//    - On gnt: store -> DONE, load -> WAIT_R. mem_req drops the cycle after gnt.
//  - WAIT_R state: on rvalid, capture the extended load into ReadData -> DONE.
//  - DONE state:
//    - done=1, stall=0; the pipeline advances at this edge.
//    - Next state IDLE unconditionally; the same instruction is never re-accepted.
//  - stall = start_legal | (state==REQ) | (state==WAIT_R).
//  - Store lanes, o = Addr[1:0]:
//    - SB: wdata={4{WrData[7:0]}},  be=4'b0001<<o.
//    - SH: wdata={2{WrData[15:0]}}, be=4'b0011<<o.
//    - SW: wdata=WrData, be=4'b1111.
//  - Loads: read mem_be=4'b1111. Select byte (o) or half (o[1]) of the captured rdata.
//    - B/H: sign-extend. BU/HU: zero-extend. W: pass through.
//  - Latency with zero wait states: store done at T+2, load done at T+3 (rvalid at T+2), T = start cycle.
//  - mem_rvalid and mem_gnt outside their waiting state are ignored.
//  - Reset mid-operation: IDLE next cycle, mem_req=0; a late rvalid is ignored and ReadData stays 0.
// TESTING
//  1. SW Addr=0x100 WrData=0xDEADBEEF, gnt at T+1 -> mem_req=1 only at T+1, be=1111, wdata=0xDEADBEEF, stall T..T+1, done T+2.
//  2. LB Addr=0x103, rdata=0x80FF0000 -> ReadData=0xFFFFFF80; same with LBU -> 0x00000080; LHU Addr=0x102 -> 0x000080FF.
//  3. SH Addr=0x102 WrData=0x00001234 -> mem_addr=0x100, be=1100, wdata=0x12341234; SB Addr=0x101 WrData=0xAB -> be=0010.
//  4. LW Addr=0x101; SH Addr=0x003; Funct3=011 load -> err pulse each, stall=0, mem_req never asserted.
//  5. LW, gnt delayed 3 cycles, rvalid 2 cycles after gnt -> mem_req/addr stable 4 cycles, stall continuous, done once.
//  6. reset in WAIT_R, then rvalid -> state IDLE, stall=0, done=0, ReadData=0; the next SW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns an EX/MEM load or store into a req/gnt/rvalid
// memory transaction, handles byte-lane steering and load extension, and stalls the pipeline.
module mem_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_i,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            Funct3,
   input  logic [DATA_WIDTH-1:0] Addr,
   input  logic [DATA_WIDTH-1:0] WrData,
   output logic                  stall,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [BE_WIDTH-1:0]   mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Loads always read the whole word; stores enable only the addressed lanes.
   function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] o, input logic we);
      logic [3:0] be;
      if (!we) begin
         be = 4'b1111;
      end else begin
         case (f3[1:0])
            2'b00:   be = 4'b0001 << o;
            2'b01:   be = 4'b0011 << o;
            default: be = 4'b1111;
         endcase
      end
      return be;
   endfunction

   function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] r);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] x;
      case (o)
         2'd0:    b = r[7:0];
         2'd1:    b = r[15:8];
         2'd2:    b = r[23:16];
         2'd3:    b = r[31:24];
         default: b = r[7:0];
      endcase
      h = o[1] ? r[31:16] : r[15:0];
      case (f3)
         3'b000:  x = {{24{b[7]}}, b};
         3'b100:  x = {24'd0, b};
         3'b001:  x = {{16{h[15]}}, h};
         3'b101:  x = {16'd0, h};
         default: x = r;
      endcase
      return x;
   endfunction

   state_t      state_r, state_nx_s;
   logic [31:0] addr_r, wdata_r;
   logic [3:0]  be_r;
   logic [2:0]  f3_r;
   logic [1:0]  off_r;
   logic        we_r;

   logic start_s, illegal_s, misalign_s, bad_s;

   // Access legality is judged on the live EX/MEM inputs in the accepting cycle.
   always_comb begin
      start_s    = (state_r == IDLE) && valid_i && (MemRead || MemWrite);
      illegal_s  = (MemRead && MemWrite)
                 || (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111)
                 || (MemWrite && Funct3[2]);
      misalign_s = ((Funct3[1:0] == 2'b01) && Addr[0])
                 || ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
      bad_s      = illegal_s || misalign_s;
   end

   // Next-state and control outputs; reset forces everything quiet in the same cycle.
   always_comb begin
      state_nx_s = state_r;
      stall      = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      mem_req    = 1'b0;
      if (reset) begin
         state_nx_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s && bad_s) begin
                  err = 1'b1;
               end else if (start_s) begin
                  stall      = 1'b1;
                  state_nx_s = REQ;
               end else begin
                  state_nx_s = IDLE;
               end
            end
            REQ: begin
               mem_req = 1'b1;
               stall   = 1'b1;
               if (mem_gnt) begin
                  state_nx_s = we_r ? DONE : WAIT_R;
               end else begin
                  state_nx_s = REQ;
               end
            end
            WAIT_R: begin
               stall = 1'b1;
               if (mem_rvalid) begin
                  state_nx_s = DONE;
               end else begin
                  state_nx_s = WAIT_R;
               end
            end
            DONE: begin
               done       = 1'b1;
               state_nx_s = IDLE;
            end
            default: state_nx_s = IDLE;
         endcase
      end
   end

   // State register, latched request fields and captured load result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         addr_r   <= 32'd0;
         wdata_r  <= 32'd0;
         be_r     <= 4'd0;
         f3_r     <= 3'd0;
         off_r    <= 2'd0;
         we_r     <= 1'b0;
         ReadData <= 32'd0;
      end else begin
         state_r <= state_nx_s;
         if (start_s && !bad_s) begin
            addr_r  <= {Addr[31:2], 2'b00};
            off_r   <= Addr[1:0];
            f3_r    <= Funct3;
            we_r    <= MemWrite;
            be_r    <= calc_be(Funct3, Addr[1:0], MemWrite);
            wdata_r <= MemWrite ? calc_wdata(Funct3, WrData) : 32'd0;
         end
         if ((state_r == WAIT_R) && mem_rvalid) begin
            ReadData <= load_ext(f3_r, off_r, mem_rdata);
         end
      end
   end

   assign mem_addr  = addr_r;
   assign mem_we    = we_r;
   assign mem_be    = be_r;
   assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected memory requests and load results
// are queued when an access is launched and compared when the DUT produces them.
module tb_mem_access_unit;

   logic        clk, reset, valid_i, MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] Addr, WrData;
   logic        stall, done, err, mem_req, mem_we;
   logic [31:0] ReadData, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   req_t        req_q[$];
   logic [31:0] rd_q[$];

   mem_access_unit #(.DATA_WIDTH(32), .BE_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .stall(stall), .done(done),
      .ReadData(ReadData), .err(err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one access, act as memory with the given delays, check every cycle until done.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_rd);
      req_t r;
      int   cycle, req_cycles, gnt_cycle, exp_done;
      logic granted, fin;
      r.addr = {a[31:2], 2'b00}; r.we = wr; r.be = exp_be; r.wdata = exp_wdata;
      req_q.push_back(r);
      if (rd) rd_q.push_back(exp_rd);
      valid_i = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
      mem_rdata = rdata; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      cycle = 0; req_cycles = 0; gnt_cycle = 0; granted = 1'b0; fin = 1'b0;
      exp_done = rd ? (gnt_dly + 2 + rv_dly) : (gnt_dly + 2);
      while (!fin) begin
         @(negedge clk);
         n_cmp++;
         if (mem_req !== ((cycle >= 1) && !granted)) begin
            n_bad++; $display("FAIL mem_req cycle %0d: got %b", cycle, mem_req);
         end
         n_cmp++;
         if (stall !== !done) begin
            n_bad++; $display("FAIL stall cycle %0d: got %b done %b", cycle, stall, done);
         end
         if (mem_req && !granted) begin
            req_cycles++;
            n_cmp++;
            if (mem_addr !== req_q[0].addr || mem_we !== req_q[0].we || mem_be !== req_q[0].be
                || (req_q[0].we && mem_wdata !== req_q[0].wdata)) begin
               n_bad++;
               $display("FAIL req fields: got a=%h we=%b be=%b wd=%h, want a=%h we=%b be=%b wd=%h",
                        mem_addr, mem_we, mem_be, mem_wdata,
                        req_q[0].addr, req_q[0].we, req_q[0].be, req_q[0].wdata);
            end
         end
         if (done) begin
            fin = 1'b1;
            n_cmp++;
            if (cycle != exp_done) begin
               n_bad++; $display("FAIL done latency: got %0d want %0d", cycle, exp_done);
            end
            if (rd) begin
               n_cmp++;
               if (ReadData !== rd_q[0]) begin
                  n_bad++; $display("FAIL ReadData: got %h want %h", ReadData, rd_q[0]);
               end
               void'(rd_q.pop_front());
            end
         end
         mem_gnt    = mem_req && !granted && (req_cycles == gnt_dly + 1);
         if (mem_gnt) begin
            granted = 1'b1; gnt_cycle = cycle;
            void'(req_q.pop_front());
         end
         mem_rvalid = rd && granted && (cycle == gnt_cycle + rv_dly);
         if (cycle > 40) begin
            n_cmp++; n_bad++; fin = 1'b1;
            $display("FAIL timeout: no done after %0d cycles", cycle);
         end
         @(posedge clk); #1;
         cycle++;
      end
      valid_i = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      n_cmp++;
      if (req_cycles != gnt_dly + 1) begin
         n_bad++; $display("FAIL req cycles: got %0d want %0d", req_cycles, gnt_dly + 1);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
         n_bad++; $display("FAIL after done: done=%b stall=%b req=%b want 000", done, stall, mem_req);
      end
      @(posedge clk); #1;
   endtask

   // Present a bad access for one cycle and expect a lone err pulse with no request.
   task automatic check_err(input string nm, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a);
      valid_i = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = 32'h5555_AAAA;
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
         n_bad++; $display("FAIL %s: err=%b stall=%b req=%b want 1,0,0", nm, err, stall, mem_req);
      end
      @(posedge clk); #1;
      valid_i = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL %s after: err=%b stall=%b req=%b done=%b want 0", nm, err, stall, mem_req, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; valid_i = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
      Addr = 32'd0; WrData = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({stall, done, err, mem_req, mem_we} !== 5'b0 || ReadData !== 32'd0 ||
          mem_addr !== 32'd0 || mem_be !== 4'd0 || mem_wdata !== 32'd0) begin
         n_bad++; $display("FAIL reset state: ctl=%b rd=%h a=%h be=%b wd=%h want all 0",
                           {stall, done, err, mem_req, mem_we}, ReadData, mem_addr, mem_be, mem_wdata);
      end
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ReadData !== 32'd0 || mem_req !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL idle gnt/rvalid: rd=%h req=%b done=%b want 0", ReadData, mem_req, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'd0, 4'b1111, 32'hDEAD_BEEF, 32'd0);
      run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 0, 0, 32'd0, 4'b1100, 32'h1234_1234, 32'd0);
      run_access(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00AB, 0, 0, 32'd0, 4'b0010, 32'hABAB_ABAB, 32'd0);
   endtask

   task automatic test_load();
      run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 1, 32'h80FF_0000, 4'b1111, 32'd0, 32'hFFFF_FF80);
      run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 0, 1, 32'h80FF_0000, 4'b1111, 32'd0, 32'h0000_0080);
      run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 0, 1, 32'h80FF_0000, 4'b1111, 32'd0, 32'h0000_80FF);
      run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 0, 1, 32'h80FF_0000, 4'b1111, 32'd0, 32'hFFFF_80FF);
      run_access(1'b1, 1'b0, 3'b000, 32'h100, 32'd0, 0, 1, 32'h1234_5678, 4'b1111, 32'd0, 32'h0000_0078);
   endtask

   task automatic test_errors();
      check_err("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h101);
      check_err("sh_misaligned", 1'b0, 1'b1, 3'b001, 32'h003);
      check_err("funct3_011",    1'b1, 1'b0, 3'b011, 32'h100);
      check_err("store_bu",      1'b0, 1'b1, 3'b100, 32'h100);
      check_err("read_and_write", 1'b1, 1'b1, 3'b010, 32'h100);
   endtask

   task automatic test_wait_states();
      run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 3, 2, 32'h1234_5678, 4'b1111, 32'd0, 32'h1234_5678);
   endtask

   task automatic test_back_to_back();
      run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 0, 1, 32'hCAFE_F00D, 4'b1111, 32'd0, 32'hCAFE_F00D);
      run_access(1'b0, 1'b1, 3'b000, 32'h47, 32'h0000_0011, 1, 0, 32'd0, 4'b1000, 32'h1111_1111, 32'd0);
      @(negedge clk);
      n_cmp++;
      if (ReadData !== 32'hCAFE_F00D) begin
         n_bad++; $display("FAIL ReadData hold: got %h want cafef00d", ReadData);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      valid_i = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h300;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      mem_gnt = mem_req;
      @(posedge clk); #1;
      mem_gnt = 1'b0; valid_i = 1'b0; MemRead = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      n_cmp++;
      if (stall !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || ReadData !== 32'd0) begin
         n_bad++; $display("FAIL reset mid: stall=%b done=%b req=%b rd=%h want 0", stall, done, mem_req, ReadData);
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || ReadData !== 32'd0) begin
         n_bad++; $display("FAIL late rvalid: done=%b rd=%h want 0", done, ReadData);
      end
      @(posedge clk); #1;
      run_access(1'b0, 1'b1, 3'b010, 32'h104, 32'h0BAD_CAFE, 0, 0, 32'd0, 4'b1111, 32'h0BAD_CAFE, 32'd0);
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_errors();
      test_wait_states();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
